// File: rtl/pipe_pkg.sv
// Shared types for the two-entry skid pipeline stage.
package pipe_pkg;

    // Occupancy of the stage: nothing, main entry only, main plus skid entry.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy state machine for pipe_skid_stage.
// Produces the state plus main/skid register load enables and the main-input
// select (0 = InData, 1 = skid register).
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        InValid,
    input  logic        OutReady,
    input  logic        Flush,
    output skid_state_t state,
    output logic        main_ld,
    output logic        skid_ld,
    output logic        main_sel
);

    skid_state_t state_nxt;
    logic        in_fire;
    logic        out_fire;

    // State register; reset empties the stage immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and register load decode.
    always_comb begin
        state_nxt = state;
        main_ld   = 1'b0;
        skid_ld   = 1'b0;
        main_sel  = 1'b0;
        in_fire   = InValid && (state != FULL);
        out_fire  = OutReady && (state != EMPTY);
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = BUSY;
                    main_ld   = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    state_nxt = FULL;
                    skid_ld   = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nxt = BUSY;
                    main_ld   = 1'b1;
                    main_sel  = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        // Flush discards everything, including data accepted this cycle.
        if (Flush) begin
            state_nxt = EMPTY;
            main_ld   = 1'b0;
            skid_ld   = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready skid stage with registered InReady.
// LoadEn is the downstream flop enable (OutValid & OutReady).
// Optional macro PIPE_SKID_PERFCNT_EN adds the saturating StallCnt output.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    output logic             LoadEn
`ifdef PIPE_SKID_PERFCNT_EN
    ,
    output logic [CNTW-1:0]  StallCnt
`endif
);

    skid_state_t      state;
    logic             main_ld;
    logic             skid_ld;
    logic             main_sel;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    pipe_skid_ctrl u_ctrl (
        .clk      (clk),
        .reset_n  (reset_n),
        .InValid  (InValid),
        .OutReady (OutReady),
        .Flush    (Flush),
        .state    (state),
        .main_ld  (main_ld),
        .skid_ld  (skid_ld),
        .main_sel (main_sel)
    );

    // Status outputs decoded from the state flop only.
    always_comb begin
        OutValid = (state != EMPTY);
        InReady  = (state != FULL);
        OutData  = main_q;
        LoadEn   = OutValid && OutReady;
    end

    // Payload registers (no reset); main refills from skid when draining FULL.
    always_ff @(posedge clk) begin
        if (main_ld) begin
            main_q <= main_sel ? skid_q : InData;
        end
        if (skid_ld) begin
            skid_q <= InData;
        end
    end

`ifdef PIPE_SKID_PERFCNT_EN
    // Saturating stall counter; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            StallCnt <= '0;
        end else if (OutValid && !OutReady && (StallCnt != '1)) begin
            StallCnt <= StallCnt + CNTW'(1);
        end
    end
`else
    // CNTW only sizes the counter; keep it referenced when the counter is absent.
    logic [CNTW-1:0] unused_cntw;
    always_comb unused_cntw = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: queue-based occupancy model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_skid_stage;

    localparam int WIDTH = 32;
    localparam int CNTW  = 4;
    localparam int unsigned SAT = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             Flush;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] InData;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] OutData;
    logic             LoadEn;
`ifdef PIPE_SKID_PERFCNT_EN
    logic [CNTW-1:0]  StallCnt;
`endif

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .InData   (InData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .LoadEn   (LoadEn)
`ifdef PIPE_SKID_PERFCNT_EN
        ,
        .StallCnt (StallCnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: a FIFO of at most two payloads plus a stall tally.
    logic [WIDTH-1:0] mq[$];
    int unsigned      m_stall = 0;

    always @(posedge clk or negedge reset_n) begin
        bit inf, outf;
        if (!reset_n) begin
            mq.delete();
            m_stall = 0;
        end else begin
            inf  = InValid && (mq.size() < 2);
            outf = OutReady && (mq.size() > 0);
            if ((mq.size() > 0) && !OutReady && (m_stall < SAT)) m_stall++;
            if (Flush) begin
                mq.delete();
            end else begin
                if (outf) void'(mq.pop_front());
                if (inf) mq.push_back(InData);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("OutValid", 64'(OutValid), 64'(mq.size() > 0));
            chk("InReady", 64'(InReady), 64'(mq.size() < 2));
            chk("LoadEn", 64'(LoadEn), 64'((mq.size() > 0) && OutReady));
            if (mq.size() > 0) chk("OutData", 64'(OutData), 64'(mq[0]));
`ifdef PIPE_SKID_PERFCNT_EN
            chk("StallCnt", 64'(StallCnt), 64'(m_stall));
`endif
        end
    end

    task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
        InValid  = iv;
        InData   = d;
        OutReady = ordy;
        Flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        #1 reset_n = 1'b1;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        cmp_en = 1'b1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst OutValid", 64'(OutValid), 64'd0);
        chk("rst InReady", 64'(InReady), 64'd1);
        chk("rst LoadEn", 64'(LoadEn), 64'd0);
`ifdef PIPE_SKID_PERFCNT_EN
        chk("rst StallCnt", 64'(StallCnt), 64'd0);
`endif

        // Single transfer: one-cycle latency
        drive(1'b1, 32'hA5, 1'b1, 1'b0);
        @(negedge clk);
        chk("a5 InReady pre", 64'(InReady), 64'd1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("a5 OutValid", 64'(OutValid), 64'd1);
        chk("a5 OutData", 64'(OutData), 64'hA5);
        chk("a5 LoadEn", 64'(LoadEn), 64'd1);
        chk("a5 InReady", 64'(InReady), 64'd1);
        tick();

        // Back-to-back stream at full throughput
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, WIDTH'(i), 1'b1, 1'b0);
            @(negedge clk);
            chk("stream InReady", 64'(InReady), 64'd1);
            if (i > 1) chk("stream OutData", 64'(OutData), 64'(i - 1));
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("stream last", 64'(OutData), 64'h4);
        tick();

        // Late stall absorbed by the skid entry
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h12, 1'b1, 1'b0);
        @(negedge clk);
        chk("skid InReady", 64'(InReady), 64'd0);
        chk("skid OutData", 64'(OutData), 64'h10);
        chk("skid LoadEn", 64'(LoadEn), 64'd1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("skid drain data", 64'(OutData), 64'h11);
        chk("skid drain rdy", 64'(InReady), 64'd1);
        tick();
        @(negedge clk);
        chk("skid empty", 64'(OutValid), 64'd0);

        // Flush while FULL discards skid and incoming data
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h21, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h22, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush OutValid", 64'(OutValid), 64'd0);
        chk("flush InReady", 64'(InReady), 64'd1);
        repeat (3) tick();

        // Asynchronous reset mid-cycle while FULL
        drive(1'b1, 32'h30, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h31, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst OutValid", 64'(OutValid), 64'd0);
        chk("arst InReady", 64'(InReady), 64'd1);
        chk("arst LoadEn", 64'(LoadEn), 64'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        tick();

`ifdef PIPE_SKID_PERFCNT_EN
        // Stall counter saturation, survives Flush, cleared by reset
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (20) tick();
        @(negedge clk);
        chk("stall sat", 64'(StallCnt), 64'(SAT));
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall flush", 64'(StallCnt), 64'(SAT));
        reset_n = 1'b0;
        #1;
        chk("stall rst", 64'(StallCnt), 64'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        tick();
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [WIDTH-1:0] rd;
            int unsigned      bias;
            rd   = WIDTH'($urandom);
            bias = (c / 500) % 3;
            drive(1'($urandom_range(1)),
                  rd,
                  (bias == 0) ? 1'b1 : ((bias == 1) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0)),
                  ($urandom_range(31) == 0));
            tick();
        end

        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Two-entry valid/ready pipeline stage with a registered InReady and no combinational path from OutReady to InReady.
- Sits directly upstream of a bank of enabled pipeline flops.
- Produces OutData plus a one-cycle load strobe (LoadEn) that drives the downstream flops' enable.
- Lets a stall raised late in a cycle be absorbed by the skid entry instead of rippling back combinationally.

Parameters:
WIDTH, 32, payload width in bits
CNTW, 16, width of stall counter (only used when PIPE_SKID_PERFCNT_EN defined)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
Flush  input  1  synchronous clear of both entries
InValid  input  1  upstream has data
InReady  output  1  stage can accept (registered)
InData  input  WIDTH  upstream payload
OutValid  output  1  main entry holds data
OutReady  input  1  downstream accepts this cycle
OutData  output  WIDTH  main entry payload
LoadEn  output  1  OutValid & OutReady; enable for downstream flops
StallCnt  output  CNTW  stall-cycle count (only when PIPE_SKID_PERFCNT_EN defined)

Behaviour:
- Reset (reset_n low, asynchronous): state EMPTY, OutValid=0, InReady=1, LoadEn=0, StallCnt=0.
- Main and skid data registers have no reset. OutData is don't-care while OutValid=0.
- States (2-bit): EMPTY (0 entries), BUSY (main valid), FULL (main+skid valid).
- Fire definitions: InFire = InValid & InReady; OutFire = OutValid & OutReady.
- Outputs:
  - OutValid = (state != EMPTY).
  - InReady = (state != FULL), decoded from the state flop only.
  - OutData = main register.
  - LoadEn = OutFire, combinational.
- Transitions (Flush=0):
  - EMPTY: InFire -> BUSY, main<=InData. Else stay.
  - BUSY, InFire & OutFire -> BUSY, main<=InData.
  - BUSY, InFire only -> FULL, skid<=InData.
  - BUSY, OutFire only -> EMPTY.
  - BUSY, neither -> stay.
  - FULL: InReady=0, so InValid is ignored. OutFire -> BUSY, main<=skid. Else stay, data held.
- Latency: data accepted in cycle N appears on OutData/OutValid in cycle N+1 when the stage was EMPTY. Throughput is 1/cycle while OutReady is held high.
- Ordering: strict FIFO; skid data is never overtaken by later input.
- Flush=1: next state EMPTY regardless of InFire/OutFire.
  - Data accepted that cycle is discarded.
  - LoadEn still reflects OutFire in the flush cycle; the downstream load occurs.
  - InReady=1 from the following cycle.
- reset_n asserted mid-transfer: state immediately EMPTY, in-flight entries lost, no LoadEn pulse.
- InValid low with InData changing: no register update.

Optional Feature:
- Macro: PIPE_SKID_PERFCNT_EN.
- Defined:
  - StallCnt port present.
  - Increments each cycle OutValid=1 & OutReady=0.
  - Saturates at 2^CNTW-1.
  - Cleared only by reset_n; Flush does not clear it.
- Undefined: StallCnt port and counter logic absent; all other behaviour identical.

Decomposition:
- Package pipe_pkg holds typedef enum logic [1:0] skid_state_t {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}.
- One sub-module, pipe_skid_ctrl: the state machine.
  - Inputs: InValid, OutReady, Flush.
  - Outputs: state, main/skid load enables, mux select.
- Data registers and the main-input mux (InData vs skid) stay in the top module.

Test Plan:
- Reset then InValid=1, InData=0xA5, OutReady=1 for 1 cycle -> next cycle OutValid=1, OutData=0xA5, LoadEn=1; InReady=1 throughout.
- Stream 0x1,0x2,0x3,0x4 with OutReady=1 -> OutData 0x1..0x4 on consecutive cycles, InReady never drops.
- In BUSY holding 0x10, drop OutReady and present 0x11 -> state FULL, InReady=0 next cycle, OutData=0x10. Raise OutReady -> 0x10 then 0x11 delivered, InReady=1 one cycle after first OutFire.
- In FULL (0x20 main, 0x21 skid), Flush=1 with InValid=1, InData=0x22 -> next cycle OutValid=0, InReady=1; 0x21 and 0x22 never appear.
- Assert reset_n=0 asynchronously mid-cycle while FULL -> OutValid=0, InReady=1 immediately, before the next clk edge.
- With PIPE_SKID_PERFCNT_EN, CNTW=4: hold OutValid=1, OutReady=0 for 20 cycles -> StallCnt saturates at 15. Flush leaves it at 15; reset_n clears it to 0.
